video_scandbl_buf: RTL and testbench

Parametrised line-buffer scandoubler, the successor to the fixed 6-bit scandoubler in the video pipeline.
- Captures one TV-rate line of palette colour into one half of a ping-pong buffer pair.
- Replays the previously completed line at the VGA rate, once per scanout_start (normally twice per input line).
- Adds over what the fixed block has: configurable colour width and line length, per-line length tracking, blank fill past end-of-line, and a sticky overflow flag.
- Sits between video_palframe colour output and video_outmux.

---
 rtl/video_scandbl_buf.sv | 167 ++++++++++++++++
 tb/tb_video_scandbl_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scandbl_buf.sv
// -----------------------------------------------------------------------------
// video_scandbl_buf
//   Line-buffer scandoubler. Each TV-rate input line is captured into one half
//   of a ping-pong RAM. The previously completed line is replayed at the VGA
//   rate once per scanout_start, which normally arrives twice per input line.
//   If a replay runs past the end of the stored line, the output is BLANK.
//
// Ports
//   clk, rst       system clock; asynchronous active-high reset
//   scanin_start   pulse: close the current input line, start a new one
//   pix_in_stb     input pixel strobe; pix_in is the input colour
//   scanout_start  pulse: replay the last completed line from pixel 0
//   pix_out_stb    output pixel strobe; pix_out/pix_out_vld update 1 clk later
//   pix_out        registered output colour (BLANK when no stored pixel)
//   pix_out_vld    pix_out holds a stored pixel rather than fill
//   last_len       pixel count of the last completed input line
//   ovf            sticky: an input line exceeded LINE_LEN pixels
//   clr_ovf        synchronous clear of ovf (a same-cycle set wins)
// -----------------------------------------------------------------------------
module video_scandbl_buf #(
  parameter int                 COLOR_W  = 6,
  parameter int                 LINE_LEN = 448,
  parameter int                 ADDR_W   = 9,
  parameter logic [COLOR_W-1:0] BLANK    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scanin_start,
  input  logic               pix_in_stb,
  input  logic [COLOR_W-1:0] pix_in,
  input  logic               scanout_start,
  input  logic               pix_out_stb,
  output logic [COLOR_W-1:0] pix_out,
  output logic               pix_out_vld,
  output logic [ADDR_W:0]    last_len,
  output logic               ovf,
  input  logic               clr_ovf
);

  // Counters are one bit wider than the address so LINE_LEN itself fits.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  // Ping-pong line store: first index is the buffer half, second the pixel.
  logic [COLOR_W-1:0] mem [0:1][0:LINE_LEN-1];

  // ---------------------------------------------------------------- write side
  logic              wr_buf;
  logic [ADDR_W:0]   wr_ptr;
  logic              wr_buf_nxt;
  logic [ADDR_W:0]   last_len_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              ovf_set;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_buf_nxt   = wr_buf;
    last_len_nxt = last_len;
    wr_addr      = wr_ptr[ADDR_W-1:0];
    wr_en        = 1'b0;
    ovf_set      = 1'b0;
    if (scanin_start) begin
      // A pixel arriving with scanin_start is pixel 0 of the new line.
      wr_buf_nxt   = ~wr_buf;
      last_len_nxt = wr_ptr;
      wr_addr      = '0;
      wr_en        = pix_in_stb;
    end else if (pix_in_stb) begin
      if (wr_ptr < LEN_MAX) wr_en   = 1'b1;
      else                  ovf_set = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_buf   <= 1'b0;
      wr_ptr   <= '0;
      last_len <= '0;
      ovf      <= 1'b0;
    end else begin
      wr_buf   <= wr_buf_nxt;
      last_len <= last_len_nxt;
      if (scanin_start)  wr_ptr <= pix_in_stb ? PTR_ONE : '0;
      else if (wr_en)    wr_ptr <= wr_ptr + PTR_ONE;
      if (ovf_set)       ovf <= 1'b1;
      else if (clr_ovf)  ovf <= 1'b0;
    end
  end

  // NOTE: the line RAM has no reset so it maps onto block RAM; its contents
  // are never observed before being written because last_len starts at 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_buf_nxt][wr_addr] <= pix_in;
  end

  // ----------------------------------------------------------------- read side
  rd_state_t       rd_state, rd_state_nxt;
  logic            rd_buf, rd_buf_nxt;
  logic [ADDR_W:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0] rd_len, rd_len_nxt;
  logic            rd_avail;
  logic            rd_en;
  logic            blank_en;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_buf_nxt   = rd_buf;
    rd_ptr_nxt   = rd_ptr;
    rd_len_nxt   = rd_len;
    rd_en        = 1'b0;
    blank_en     = 1'b0;
    rd_avail     = (rd_state == RD_RUN) && (rd_ptr < rd_len);
    if (scanout_start) begin
      // Uses the post-scanin values so a coincident scanin_start replays the
      // line it just closed. A strobe in this cycle is not accepted.
      rd_state_nxt = RD_RUN;
      rd_buf_nxt   = ~wr_buf_nxt;
      rd_len_nxt   = last_len_nxt;
      rd_ptr_nxt   = '0;
    end else begin
      if (rd_state == RD_RUN && !rd_avail) rd_state_nxt = RD_IDLE;
      if (pix_out_stb) begin
        if (rd_avail) begin
          rd_en      = 1'b1;
          rd_ptr_nxt = rd_ptr + PTR_ONE;
        end else begin
          blank_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_buf   <= 1'b1;
      rd_ptr   <= '0;
      rd_len   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_buf   <= rd_buf_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_len   <= rd_len_nxt;
    end
  end

  // Registered RAM read; outputs hold between accepted strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out     <= BLANK;
      pix_out_vld <= 1'b0;
    end else if (rd_en) begin
      pix_out     <= mem[rd_buf][rd_ptr[ADDR_W-1:0]];
      pix_out_vld <= 1'b1;
    end else if (blank_en) begin
      pix_out     <= BLANK;
      pix_out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_scandbl_buf.sv
// -----------------------------------------------------------------------------
// tb_video_scandbl_buf
//   Directed bench for video_scandbl_buf with default parameters (6-bit colour,
//   448-pixel lines, BLANK = 0). Each stimulus cycle drives inputs on the
//   falling edge and samples outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_video_scandbl_buf;

  logic       clk;
  logic       rst;
  logic       scanin_start;
  logic       pix_in_stb;
  logic [5:0] pix_in;
  logic       scanout_start;
  logic       pix_out_stb;
  logic [5:0] pix_out;
  logic       pix_out_vld;
  logic [9:0] last_len;
  logic       ovf;
  logic       clr_ovf;

  int n_vec = 0;
  int n_bad = 0;

  video_scandbl_buf dut (
    .clk          (clk),
    .rst          (rst),
    .scanin_start (scanin_start),
    .pix_in_stb   (pix_in_stb),
    .pix_in       (pix_in),
    .scanout_start(scanout_start),
    .pix_out_stb  (pix_out_stb),
    .pix_out      (pix_out),
    .pix_out_vld  (pix_out_vld),
    .last_len     (last_len),
    .ovf          (ovf),
    .clr_ovf      (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sin, pstb, sout, ostb, clr;
    logic [5:0] pix;
    bit         ck_pix;
    logic [5:0] e_pix;
    bit         e_vld;
    bit         ck_len;
    logic [9:0] e_len;
    bit         ck_ovf;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs are single-cycle and dropped after the edge.
  task automatic cyc(input bit sin, input bit pstb, input logic [5:0] pix,
                     input bit sout, input bit ostb, input bit clr);
    @(negedge clk);
    scanin_start  = sin;
    pix_in_stb    = pstb;
    pix_in        = pix;
    scanout_start = sout;
    pix_out_stb   = ostb;
    clr_ovf       = clr;
    @(posedge clk);
    #1;
    scanin_start  = 1'b0;
    pix_in_stb    = 1'b0;
    pix_in        = '0;
    scanout_start = 1'b0;
    pix_out_stb   = 1'b0;
    clr_ovf       = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [5:0] e_pix, input bit e_vld);
    check({name, " pix"}, 32'(pix_out), 32'(e_pix));
    check({name, " vld"}, 32'(pix_out_vld), 32'(e_vld));
  endtask

  function automatic vec_t vin(bit sin, bit pstb, logic [5:0] pix, bit sout, bit ostb, bit clr);
    vec_t v;
    v        = '{default: 0};
    v.sin    = sin;
    v.pstb   = pstb;
    v.pix    = pix;
    v.sout   = sout;
    v.ostb   = ostb;
    v.clr    = clr;
    return v;
  endfunction

  function automatic vec_t xpix(vec_t v, logic [5:0] e_pix, bit e_vld);
    v.ck_pix = 1'b1;
    v.e_pix  = e_pix;
    v.e_vld  = e_vld;
    return v;
  endfunction

  function automatic vec_t xlen(vec_t v, logic [9:0] e_len);
    v.ck_len = 1'b1;
    v.e_len  = e_len;
    return v;
  endfunction

  function automatic vec_t xovf(vec_t v, bit e_ovf);
    v.ck_ovf = 1'b1;
    v.e_ovf  = e_ovf;
    return v;
  endfunction

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      cyc(tbl[i].sin, tbl[i].pstb, tbl[i].pix, tbl[i].sout, tbl[i].ostb, tbl[i].clr);
      if (tbl[i].ck_pix) check_out($sformatf("%s[%0d]", tag, i), tbl[i].e_pix, tbl[i].e_vld);
      if (tbl[i].ck_len)
        check($sformatf("%s[%0d] last_len", tag, i), 32'(last_len), 32'(tbl[i].e_len));
      if (tbl[i].ck_ovf)
        check($sformatf("%s[%0d] ovf", tag, i), 32'(ovf), 32'(tbl[i].e_ovf));
    end
    tbl.delete();
  endtask

  initial begin
    rst           = 1'b1;
    scanin_start  = 1'b0;
    pix_in_stb    = 1'b0;
    pix_in        = '0;
    scanout_start = 1'b0;
    pix_out_stb   = 1'b0;
    clr_ovf       = 1'b0;

    // ---- reset state
    #3;
    check_out("reset", 6'h00, 1'b0);
    check("reset last_len", 32'(last_len), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- 1: full 448-pixel line, slow input, two replays
    for (int i = 0; i < 448; i++) begin
      cyc(0, 1, 6'(i % 64), 0, 0, 0);
      repeat (3) cyc(0, 0, 6'h00, 0, 0, 0);
    end
    cyc(1, 0, 6'h00, 0, 0, 0);
    check("t1 last_len", 32'(last_len), 32'd448);
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 6'h00, 1, 0, 0);
      for (int i = 0; i < 448; i++) begin
        cyc(0, 0, 6'h00, 0, 1, 0);
        check_out($sformatf("t1 rep%0d px%0d", r, i), 6'(i % 64), 1'b1);
        cyc(0, 0, 6'h00, 0, 0, 0);
      end
    end
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t1 past end", 6'h00, 1'b0);

    // ---- 2: 10-pixel line replayed with 12 strobes, one idle hold cycle
    for (int i = 0; i < 10; i++) tbl.push_back(xlen(vin(0, 1, 6'(i), 0, 0, 0), 10'd448));
    tbl.push_back(xlen(vin(1, 0, 6'h00, 0, 0, 0), 10'd10));
    tbl.push_back(vin(0, 0, 6'h00, 1, 0, 0));
    for (int i = 0; i < 12; i++) begin
      tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 1, 0), (i < 10) ? 6'(i) : 6'h00, i < 10));
      if (i == 4) tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 0, 0), 6'd4, 1'b1));
    end
    run_tbl("t2");

    // ---- 3: 450-pixel line overflows; clear; set beats clear
    for (int i = 0; i < 450; i++) begin
      cyc(0, 1, 6'((i + 5) % 64), 0, 0, 0);
      check($sformatf("t3 ovf after stb%0d", i + 1), 32'(ovf), (i >= 448) ? 32'd1 : 32'd0);
    end
    cyc(1, 0, 6'h00, 0, 0, 0);
    check("t3 last_len", 32'(last_len), 32'd448);
    cyc(0, 0, 6'h00, 1, 0, 0);
    for (int i = 0; i < 448; i++) begin
      cyc(0, 0, 6'h00, 0, 1, 0);
      check_out($sformatf("t3 px%0d", i), 6'((i + 5) % 64), 1'b1);
      cyc(0, 0, 6'h00, 0, 0, 0);
    end
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t3 past end", 6'h00, 1'b0);
    check("t3 ovf sticky", 32'(ovf), 32'd1);
    cyc(0, 0, 6'h00, 0, 0, 1);
    check("t3 ovf cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 448; i++) cyc(0, 1, 6'(i % 64), 0, 0, 0);
    check("t3 full no ovf", 32'(ovf), 32'd0);
    cyc(0, 1, 6'h3F, 0, 0, 1);
    check("t3 set beats clr", 32'(ovf), 32'd1);
    cyc(0, 0, 6'h00, 0, 0, 1);
    check("t3 ovf cleared 2", 32'(ovf), 32'd0);

    // ---- 4: pixel coincident with scanin_start becomes pixel 0
    tbl.push_back(xovf(xlen(vin(1, 1, 6'h2A, 0, 0, 0), 10'd448), 1'b0));
    tbl.push_back(vin(0, 1, 6'h11, 0, 0, 0));
    tbl.push_back(vin(0, 1, 6'h12, 0, 0, 0));
    tbl.push_back(xlen(vin(1, 0, 6'h00, 0, 0, 0), 10'd3));
    tbl.push_back(vin(0, 0, 6'h00, 1, 0, 0));
    tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 1, 0), 6'h2A, 1'b1));
    tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 1, 0), 6'h11, 1'b1));
    tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 1, 0), 6'h12, 1'b1));
    tbl.push_back(xpix(vin(0, 0, 6'h00, 0, 1, 0), 6'h00, 1'b0));
    run_tbl("t4");

    // ---- 5: scanin_start mid-replay leaves the running replay alone
    for (int i = 0; i < 5; i++) cyc(0, 1, 6'(8'h30 + i), 0, 0, 0);
    cyc(0, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 old px0", 6'h2A, 1'b1);
    cyc(1, 0, 6'h00, 0, 0, 0);
    check("t5 last_len", 32'(last_len), 32'd5);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 old px1", 6'h11, 1'b1);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 old px2", 6'h12, 1'b1);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 old end", 6'h00, 1'b0);
    cyc(0, 0, 6'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 6'h00, 0, 1, 0);
      check_out($sformatf("t5 new px%0d", i), (i < 5) ? 6'(8'h30 + i) : 6'h00, i < 5);
    end
    // scanin_start and scanout_start together replay the line just closed
    cyc(0, 1, 6'h3E, 0, 0, 0);
    cyc(0, 1, 6'h3F, 0, 0, 0);
    cyc(1, 0, 6'h00, 1, 0, 0);
    check("t5 same-cycle last_len", 32'(last_len), 32'd2);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 same-cycle px0", 6'h3E, 1'b1);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 same-cycle px1", 6'h3F, 1'b1);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t5 same-cycle end", 6'h00, 1'b0);

    // ---- 6: asynchronous reset mid-line
    cyc(0, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t6 pre-reset", 6'h3E, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'(8'h20 + i), 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_out("t6 async reset", 6'h00, 1'b0);
    check("t6 reset last_len", 32'(last_len), 32'd0);
    check("t6 reset ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t6 post-reset 0", 6'h00, 1'b0);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t6 post-reset 1", 6'h00, 1'b0);
    cyc(0, 1, 6'h07, 0, 0, 0);
    cyc(0, 1, 6'h08, 0, 0, 0);
    cyc(1, 0, 6'h00, 0, 0, 0);
    check("t6 new last_len", 32'(last_len), 32'd2);
    cyc(0, 0, 6'h00, 1, 0, 0);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t6 new px0", 6'h07, 1'b1);
    cyc(0, 0, 6'h00, 0, 1, 0);
    check_out("t6 new px1", 6'h08, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
